// File: rtl/branch_resolve_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : branch_resolve_unit
//  Description : Early branch resolution. Evaluates the branch condition
//                fields, detects mispredictions, waits for the delay slot to
//                leave exec, and then hands a redirect PC to fetch over a
//                valid/ready handshake. Also keeps a saturating count of
//                mispredicts.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_is_branch,
    input  logic                 in_cond_equal,
    input  logic                 in_cond_sign,
    input  logic                 in_negate,
    input  logic                 in_mask_equal,
    input  logic                 in_mask_sign,
    input  logic [31:0]          in_target,
    input  logic [31:0]          in_pc,
    input  logic                 in_pred_taken,
    input  logic [31:0]          in_pred_target,
    input  logic                 in_dslot_in_bundle,
    input  logic                 ds_valid,
    input  logic                 stall,
    input  logic                 flush,
    output logic                 redirect_valid,
    input  logic                 redirect_ready,
    output logic [31:0]          redirect_pc,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] mispredict_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_DS  = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] C_CNT_MAX = '1;

    state_t                 r_state;
    state_t                 w_state_next;
    logic                   r_redirect_valid;
    logic [31:0]            r_redirect_pc;
    logic [CNT_WIDTH-1:0]   r_cnt;

    logic                   w_taken;
    logic [31:0]            w_correct_pc;
    logic                   w_mispredict;
    logic                   w_accept;
    logic                   w_load;

    // Condition evaluation, architecturally correct PC and mispredict detection
    assign w_taken      = in_negate ^ ((in_mask_equal & in_cond_equal) |
                                       (in_mask_sign  & in_cond_sign));
    assign w_correct_pc = w_taken ? in_target : (in_pc + 32'd8);
    assign w_mispredict = (w_taken != in_pred_taken) |
                          (w_taken & (in_pred_target != in_target));

    // A branch is only looked at when nothing is outstanding; flush blocks it
    assign w_accept = (r_state == ST_IDLE) & in_valid & in_is_branch & ~stall & ~flush;
    assign w_load   = w_accept & w_mispredict;

    // Next-state selection; flush overrides every transition
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        w_state_next = in_dslot_in_bundle ? ST_REDIRECT : ST_WAIT_DS;
                    end
                end
                ST_WAIT_DS: begin
                    if (ds_valid && !stall) begin
                        w_state_next = ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready) begin
                        w_state_next = ST_IDLE;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // State, registered redirect handshake, target latch and saturating counter
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= ST_IDLE;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= 32'd0;
            r_cnt            <= '0;
        end else begin
            r_state          <= w_state_next;
            r_redirect_valid <= (w_state_next == ST_REDIRECT);
            if (w_load) begin
                r_redirect_pc <= w_correct_pc;
                if (r_cnt != C_CNT_MAX) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign busy           = (r_state != ST_IDLE);
    assign mispredict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_branch_resolve_unit
//  Description : Directed and randomized bench for branch_resolve_unit with a
//                transaction-level reference model of the redirect flow.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int CNT_W   = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid, in_is_branch;
    logic              in_cond_equal, in_cond_sign, in_negate, in_mask_equal, in_mask_sign;
    logic [31:0]       in_target, in_pc, in_pred_target;
    logic              in_pred_taken, in_dslot_in_bundle;
    logic              ds_valid, stall, flush;
    logic              redirect_valid, redirect_ready;
    logic [31:0]       redirect_pc;
    logic              busy;
    logic [CNT_W-1:0]  mispredict_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: one outstanding redirect, possibly still waiting on the delay slot
    bit          m_out;
    bit          m_need_ds;
    logic [31:0] m_pc;
    int          m_cnt;

    branch_resolve_unit #(.CNT_WIDTH(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_is_branch      (in_is_branch),
        .in_cond_equal     (in_cond_equal),
        .in_cond_sign      (in_cond_sign),
        .in_negate         (in_negate),
        .in_mask_equal     (in_mask_equal),
        .in_mask_sign      (in_mask_sign),
        .in_target         (in_target),
        .in_pc             (in_pc),
        .in_pred_taken     (in_pred_taken),
        .in_pred_target    (in_pred_target),
        .in_dslot_in_bundle(in_dslot_in_bundle),
        .ds_valid          (ds_valid),
        .stall             (stall),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_ready    (redirect_ready),
        .redirect_pc       (redirect_pc),
        .busy              (busy),
        .mispredict_cnt    (mispredict_cnt)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_is_branch = 0;
        in_cond_equal = 0; in_cond_sign = 0; in_negate = 0;
        in_mask_equal = 0; in_mask_sign = 0;
        in_target = 0; in_pc = 0; in_pred_taken = 0; in_pred_target = 0;
        in_dslot_in_bundle = 0; ds_valid = 0; stall = 0; flush = 0;
    endtask

    task automatic branch(input logic [31:0] pc, input logic [31:0] tgt,
                          input bit neg, input bit me, input bit ce,
                          input bit ms, input bit cs,
                          input bit pt, input logic [31:0] ptgt, input bit dsb);
        in_valid = 1; in_is_branch = 1;
        in_pc = pc; in_target = tgt;
        in_negate = neg; in_mask_equal = me; in_cond_equal = ce;
        in_mask_sign = ms; in_cond_sign = cs;
        in_pred_taken = pt; in_pred_target = ptgt; in_dslot_in_bundle = dsb;
    endtask

    // One clock: advance the model from the current inputs, then compare after the edge
    task automatic tick(input string tag);
        bit          n_out, n_need, tk, mis;
        logic [31:0] n_pc, cp;
        int          n_cnt;
        n_out = m_out; n_need = m_need_ds; n_pc = m_pc; n_cnt = m_cnt;
        if (!rst) begin
            n_out = 0; n_need = 0; n_pc = 0; n_cnt = 0;
        end else if (flush) begin
            n_out = 0; n_need = 0;
        end else if (m_out) begin
            if (m_need_ds) begin
                if (ds_valid && !stall) n_need = 0;
            end else if (redirect_ready) begin
                n_out = 0;
            end
        end else if (in_valid && in_is_branch && !stall) begin
            tk  = in_negate ^ ((in_mask_equal && in_cond_equal) || (in_mask_sign && in_cond_sign));
            cp  = tk ? in_target : in_pc + 32'd8;
            mis = (tk != in_pred_taken) || (tk && (in_pred_target != in_target));
            if (mis) begin
                n_out  = 1;
                n_need = !in_dslot_in_bundle;
                n_pc   = cp;
                n_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
            end
        end
        @(posedge clk);
        #1;
        m_out = n_out; m_need_ds = n_need; m_pc = n_pc; m_cnt = n_cnt;
        chk({tag, ".valid"}, {31'd0, redirect_valid}, {31'd0, m_out && !m_need_ds});
        chk({tag, ".busy"},  {31'd0, busy},           {31'd0, m_out});
        chk({tag, ".pc"},    redirect_pc,             m_pc);
        chk({tag, ".cnt"},   {29'd0, mispredict_cnt}, m_cnt);
    endtask

    // Directed scenarios followed by a randomized run
    initial begin
        logic [31:0] held_pc;
        m_out = 0; m_need_ds = 0; m_pc = 0; m_cnt = 0;
        idle_inputs();
        redirect_ready = 0;
        rst = 0;
        tick("reset0");
        tick("reset1");
        rst = 1;
        tick("idle");

        // Predicted-not-taken BEQ that is taken, delay slot in bundle
        branch(32'h80000FF0, 32'h80001000, 0, 1, 1, 0, 0, 0, 32'h0, 1);
        tick("beq_acc");
        idle_inputs();
        chk("beq_valid", {31'd0, redirect_valid}, 32'd1);
        chk("beq_pc", redirect_pc, 32'h80001000);
        chk("beq_cnt", {29'd0, mispredict_cnt}, 32'd1);
        redirect_ready = 1;
        tick("beq_done");

        // Predicted-taken BNE that falls through, delay slot arrives 3 cycles later
        branch(32'hBFC00010, 32'hBFC00100, 1, 1, 1, 0, 0, 1, 32'hBFC00100, 0);
        tick("bne_acc");
        idle_inputs();
        tick("bne_w2");
        tick("bne_w3");
        chk("bne_wait_busy", {31'd0, busy}, 32'd1);
        chk("bne_wait_valid", {31'd0, redirect_valid}, 32'd0);
        ds_valid = 1;
        tick("bne_ds");
        ds_valid = 0;
        chk("bne_valid", {31'd0, redirect_valid}, 32'd1);
        chk("bne_pc", redirect_pc, 32'hBFC00018);
        tick("bne_done");

        // Correctly predicted taken BGEZ
        branch(32'h00001000, 32'h00002000, 0, 0, 0, 1, 1, 1, 32'h00002000, 1);
        tick("bgez");
        idle_inputs();
        chk("bgez_busy", {31'd0, busy}, 32'd0);
        chk("bgez_cnt", {29'd0, mispredict_cnt}, 32'd2);

        // Backpressure for 5 cycles, stall asserted meanwhile
        redirect_ready = 0;
        branch(32'h00000100, 32'h00000200, 0, 1, 1, 0, 0, 0, 32'h0, 1);
        tick("bp_acc");
        idle_inputs();
        held_pc = redirect_pc;
        for (int i = 0; i < 5; i++) begin
            stall = (i % 2 == 0);
            tick("bp_hold");
            chk("bp_pc_stable", redirect_pc, held_pc);
        end
        stall = 0;
        redirect_ready = 1;
        tick("bp_release");
        chk("bp_idle", {31'd0, busy}, 32'd0);

        // Flush while waiting for the delay slot
        branch(32'h00000300, 32'h00000400, 0, 1, 1, 0, 0, 0, 32'h0, 0);
        tick("fl_acc");
        idle_inputs();
        flush = 1;
        tick("fl_flush");
        flush = 0;
        chk("fl_valid", {31'd0, redirect_valid}, 32'd0);
        chk("fl_cnt", {29'd0, mispredict_cnt}, 32'd4);
        tick("fl_after");

        // ds_valid ignored while stalled
        branch(32'h00000500, 32'h00000600, 0, 1, 1, 0, 0, 0, 32'h0, 0);
        tick("st_acc");
        idle_inputs();
        ds_valid = 1; stall = 1;
        tick("st_stalled");
        stall = 0;
        tick("st_ds");
        ds_valid = 0;
        tick("st_done");

        // PC wrap on not-taken mispredict, then reset during REDIRECT
        redirect_ready = 0;
        branch(32'hFFFFFFFC, 32'h00000100, 0, 1, 0, 0, 0, 1, 32'h00000100, 1);
        tick("wrap_acc");
        idle_inputs();
        chk("wrap_pc", redirect_pc, 32'h00000004);
        rst = 0;
        tick("wrap_rst");
        rst = 1;
        chk("rst_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_pc", redirect_pc, 32'd0);
        chk("rst_cnt", {29'd0, mispredict_cnt}, 32'd0);

        // Counter saturation
        redirect_ready = 1;
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            branch(32'h00010000 + i * 16, 32'h00020000, 0, 1, 1, 0, 0, 0, 32'h0, 1);
            tick("sat_acc");
            idle_inputs();
            tick("sat_done");
        end
        chk("sat_cnt", {29'd0, mispredict_cnt}, CNT_MAX);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            rst                = ($urandom_range(0, 99) != 0);
            flush              = ($urandom_range(0, 15) == 0);
            stall              = ($urandom_range(0, 3) == 0);
            in_valid           = $urandom_range(0, 1);
            in_is_branch       = ($urandom_range(0, 3) != 0);
            in_cond_equal      = $urandom_range(0, 1);
            in_cond_sign       = $urandom_range(0, 1);
            in_negate          = $urandom_range(0, 1);
            in_mask_equal      = $urandom_range(0, 1);
            in_mask_sign       = $urandom_range(0, 1);
            in_pc              = $urandom;
            in_target          = $urandom;
            in_pred_taken      = $urandom_range(0, 1);
            in_pred_target     = $urandom_range(0, 1) ? in_target : $urandom;
            in_dslot_in_bundle = $urandom_range(0, 1);
            ds_valid           = ($urandom_range(0, 2) == 0);
            redirect_ready     = $urandom_range(0, 1);
            tick("rand");
        end

        idle_inputs();
        rst = 0;
        tick("final_rst");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of the mispredict counter.
REQ-002 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  an exec-stage instruction is presented this cycle.
REQ-005 SHALL have port in_is_branch  input  1  the presented instruction is a conditional branch.
REQ-006 SHALL have ports in_cond_equal, in_cond_sign, in_negate, in_mask_equal, in_mask_sign  input  1 each  early-resolution condition fields from the delayed forward stage.
REQ-007 SHALL have port in_target  input  32  branch target computed as pc+4+(sext(imm)<<2).
REQ-008 SHALL have port in_pc  input  32  PC of the branch.
REQ-009 SHALL have ports in_pred_taken  input  1 and in_pred_target  input  32  the fetch-time prediction.
REQ-010 SHALL have port in_dslot_in_bundle  input  1  the delay slot is issued in the same bundle as the branch.
REQ-011 SHALL have port ds_valid  input  1  the delay-slot instruction leaves the exec stage this cycle.
REQ-012 SHALL have ports stall  input  1 and flush  input  1  pipeline stall and flush.
REQ-013 SHALL have ports redirect_valid  output  1, redirect_ready  input  1, redirect_pc  output  32  the fetch redirect handshake.
REQ-014 SHALL have ports busy  output  1 (state != IDLE) and mispredict_cnt  output  CNT_WIDTH  saturating mispredict count.

Function
REQ-015 SHALL compute taken = in_negate XOR ((in_mask_equal AND in_cond_equal) OR (in_mask_sign AND in_cond_sign)).
REQ-016 SHALL compute correct_pc = taken ? in_target : in_pc+8, with addition modulo 2^32.
REQ-017 SHALL flag mispredict = (taken != in_pred_taken) OR (taken AND in_pred_target != in_target).
REQ-018 SHALL implement the states IDLE, WAIT_DS and REDIRECT.
REQ-019 SHALL accept a branch only in IDLE when in_valid & in_is_branch & ~stall & ~flush; the inputs are ignored in any other state.
REQ-020 SHALL, on an accepted branch with no mispredict, remain in IDLE with no redirect.
REQ-021 SHALL, on an accepted mispredict, register redirect_pc = correct_pc and increment mispredict_cnt.
REQ-022 SHALL go on an accepted mispredict to REDIRECT next cycle if in_dslot_in_bundle=1, otherwise to WAIT_DS.
REQ-023 SHALL move from WAIT_DS to REDIRECT on ds_valid & ~stall; ds_valid is ignored while stall=1.
REQ-024 SHALL assert redirect_valid as a registered output, high exactly while in REDIRECT.
REQ-025 SHALL hold redirect_pc stable while redirect_valid=1 and ready=0; stall SHALL NOT affect REDIRECT.
REQ-026 SHALL complete the transfer on redirect_valid & redirect_ready and return to IDLE next cycle.
REQ-027 SHALL make flush take priority over acceptance and over the WAIT_DS/REDIRECT transitions: next state IDLE, latched redirect dropped, mispredict_cnt unchanged.
REQ-028 SHALL count a transfer as delivered when flush coincides with redirect_valid & redirect_ready.
REQ-029 SHALL saturate mispredict_cnt at all-ones and never wrap.
REQ-030 SHALL have a latency of one cycle from acceptance to redirect_valid for a same-bundle delay slot, and one cycle after the qualifying ds_valid otherwise.

Reset
REQ-031 SHALL, while rst=0 at a clock edge, set state=IDLE, redirect_valid=0, redirect_pc=0, mispredict_cnt=0 and busy=0, including mid-operation.
REQ-032 SHALL give reset priority over flush, stall and all handshakes.

Verification
REQ-033 SHALL verify a predicted-not-taken BEQ (mask_equal=1, cond_equal=1), pc=0x80000FF0, target=0x80001000, dslot in bundle -> redirect_valid=1 the next cycle, redirect_pc=0x80001000, cnt=1.
REQ-034 SHALL verify a predicted-taken BNE (negate=1, mask_equal=1, cond_equal=1), pc=0xBFC00010, dslot not in bundle, ds_valid 3 cycles later -> WAIT_DS for 3 cycles, then redirect_pc=0xBFC00018.
REQ-035 SHALL verify a correctly predicted taken BGEZ with matching target -> no redirect_valid, busy=0, cnt unchanged.
REQ-036 SHALL verify redirect_ready held low for 5 cycles -> redirect_valid and redirect_pc stable, IDLE one cycle after ready=1.
REQ-037 SHALL verify flush in WAIT_DS -> IDLE next cycle, no redirect_valid, cnt retains its increment.
REQ-038 SHALL verify a not-taken mispredict at pc=0xFFFFFFFC -> redirect_pc=0x00000004, and rst=0 during REDIRECT -> all outputs zero next cycle.
